// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WIDTH-bit add done one nibble per clock on a single 4-bit ripple-carry adder.
// Define RCA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[4];
endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [3:0]       ns;
  logic             nc, last;
  rca4 u_rca (
    .a_i(a_q[{idx_q, 2'b00} +: 4]),
    .b_i(b_q[{idx_q, 2'b00} +: 4]),
    .c_i(carry_q),
    .s_o(ns),
    .c_o(nc)
  );
  assign last = idx_q == IW'(NIB - 1);
`ifdef RCA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        idx_d   = '0;
        sum_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = ns;
        carry_d = nc;
        if (last) begin
          cout_d  = nc;
          // carry into the MSB is a^b^s at bit WIDTH-1 of the final nibble
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ ns[3] ^ nc;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed bench for rca_seq_ctrl (WIDTH=16 and WIDTH=4 instances) with a
// transaction-level model; ovf checks are built when RCA_SEQ_OVF_EN is defined.
module tb_rca_seq_ctrl;
  localparam int NIB = 4;
  logic        clk = 0, rst_n = 1;
  logic        in_valid = 0, out_ready = 1, cin = 0;
  logic [15:0] a = 0, b = 0;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sum;
  logic        iv4 = 0, or4 = 1, c4 = 0;
  logic [3:0]  a4 = 0, b4 = 0, s4;
  logic        ir4, ov4, co4, bz4;
  int          checks = 0, errors = 0;
`ifdef RCA_SEQ_OVF_EN
  logic ovf, ovf4;
`endif
  always #5 clk = ~clk;
  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );
  rca_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(c4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(bz4)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic sovf(input logic [15:0] x, input logic [15:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return s > 32767 || s < -32768;
  endfunction
  // transaction model: accept in idle, result visible NIB edges later, held until taken
  logic        m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0, m_ovp = 0;
  int          m_cnt = 0;
  logic [16:0] m_res = 0;
  logic [15:0] m_sum = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0; m_res <= 0; m_sum <= 0; m_cout <= 0; m_ovf <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1;
        m_cnt  <= 1;
        m_res  <= {1'b0, a} + {1'b0, b} + 17'(cin);
        m_ovp  <= sovf(a, b, cin);
      end
    end else if (!m_done) begin
      if (m_cnt == NIB) begin
        m_done <= 1;
        m_sum  <= m_res[15:0];
        m_cout <= m_res[16];
        m_ovf  <= m_ovp;
      end else m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_busy <= 0;
      m_done <= 0;
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, m_done);
    if (!m_busy || m_done) begin
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
`ifdef RCA_SEQ_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
    end
  end
  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic [16:0] exp, input string nm);
    int lat;
    a = ta; b = tb; cin = tc; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk({nm, " in_ready_low"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, NIB);
    chk({nm, " result"}, {cout, sum}, exp);
    @(posedge clk); #1;
    chk({nm, " ready_after"}, in_ready, 1);
    chk({nm, " valid_drop"}, out_valid, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    #2 rst_n = 0;
    #1;
    chk("rst sum", sum, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst in_ready", in_ready, 1);
    do_add(16'hFFFF, 16'h0001, 0, 17'h10000, "ffff+1");
    // abort mid-RUN after two nibbles
    a = 16'h1111; b = 16'h1111; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("partial sum", sum, 16'h0022);
    rst_n = 0;
    #1;
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("abort in_ready", in_ready, 1);
    do_add(16'h0001, 16'h0001, 0, 17'h00002, "1+1");
    do_add(16'h1234, 16'h4321, 1, 17'h05556, "1234+4321+1");
    do_add(16'h0FF0, 16'h0010, 0, 17'h01000, "0ff0+0010");
    // backpressure with ignored operand traffic
    out_ready = 0;
    a = 16'hABCD; b = 16'h0000; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", lat, NIB);
    for (int i = 0; i < 5; i++) begin
      a = 16'h1111; b = 16'h2222; cin = 1; in_valid = 1;
      @(posedge clk); #1;
      chk("bp held valid", out_valid, 1);
      chk("bp held sum", sum, 16'hABCD);
      chk("bp in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp valid_drop", out_valid, 0);
    chk("bp ready", in_ready, 1);
    chk("bp sum retained", sum, 16'hABCD);
`ifdef RCA_SEQ_OVF_EN
    do_add(16'h7FFF, 16'h0001, 0, 17'h08000, "7fff+1");
    chk("ovf 7fff+1", ovf, 1);
    do_add(16'h8000, 16'h8000, 0, 17'h10000, "8000+8000");
    chk("ovf 8000+8000", ovf, 1);
    do_add(16'hFFFF, 16'h0001, 0, 17'h10000, "ffff+1 ovf");
    chk("ovf ffff+1", ovf, 0);
`endif
    // exhaustive WIDTH=4 sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++) begin
          a4 = 4'(i); b4 = 4'(j); c4 = k[0]; iv4 = 1;
          @(posedge clk); #1;
          iv4 = 0;
          chk("w4 run", ov4, 0);
          @(posedge clk); #1;
          chk("w4 valid", ov4, 1);
          chk("w4 result", {co4, s4}, 32'(i + j + k));
`ifdef RCA_SEQ_OVF_EN
          chk("w4 ovf", ovf4, (i[3] == j[3]) && ((i + j + k) >> 3 & 1) != i[3]);
`endif
          @(posedge clk); #1;
          chk("w4 ready", ir4, 1);
        end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit additions by reusing a single instance of the team's 4-bit ripple-carry adder, one nibble per clock, LSB nibble first.
- Registers the inter-nibble carry between cycles.
- Valid/ready handshake on the operand side and the result side.
- One transaction in flight at a time; sits between an operand producer and a result consumer wherever a wide add is needed without a wide adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIB (localparam), WIDTH/4, number of adder passes per transaction.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to the LSB nibble.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB nibble.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE; nibble index=0; carry reg=0; operand regs=0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- Datapath: exactly one internal 4-bit RCA instance.
  - Inputs: the selected nibble idx of the latched A and B, plus the carry reg.
  - Outputs: nibble sum and nibble cout.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch a, b; carry reg<=cin; idx<=0; sum reg<=0; go to RUN.
  - in_valid without a handshake leaves no state change.
- RUN:
  - in_ready=0.
  - Each edge: sum[4*idx+3:4*idx] <= nibble sum; carry reg <= nibble cout; idx<=idx+1.
  - When idx==NIB-1: cout<=nibble cout; go to DONE instead of incrementing.
- DONE:
  - out_valid=1; sum and cout are stable and held.
  - On out_valid && out_ready: go to IDLE; out_valid=0 next cycle.
- Latency: handshake at edge k gives out_valid=1 after edge k+NIB (WIDTH=16: 4 cycles).
  - Earliest next accept is the edge after the result handshake.
  - Throughput is therefore one transaction per NIB+2 cycles with out_ready held high.
- in_valid and operand changes during RUN/DONE are ignored; operands are latched only at the accept edge.
- out_ready while out_valid=0 has no effect.
- Operand bits are unsigned; the WIDTH+1-bit result is {cout,sum} = a+b+cin mod 2^(WIDTH+1) (exact).
- sum retains its last value after the DONE→IDLE transition until the next accept clears it.
- Reset asserted during RUN or DONE aborts immediately to reset values; the partial result is discarded.
- WIDTH=4 (NIB=1): RUN lasts exactly one cycle.

Optional Feature:
- Macro: RCA_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - Signed two's-complement overflow = (carry into bit WIDTH-1) XOR cout.
  - Carry into the MSB is computed in the final RUN cycle as a[W-1]^b[W-1]^sum[W-1] of the active nibble.
  - ovf is registered with cout, held through DONE, and reset to 0.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, out_ready=1 → sum=0x0000, cout=1; out_valid exactly 4 cycles after accept; in_ready low for RUN+DONE.
- a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0; a=0x0FF0, b=0x0010, cin=0 → sum=0x1000, cout=0 (carry crosses nibbles 1→2).
- Backpressure: result 0xABCD+0x0000, out_ready held 0 for 5 cycles → out_valid and sum=0xABCD held; in_valid with new operands ignored; after out_ready=1, one handshake; in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles → sum=0, cout=0, out_valid=0, busy=0 immediately; after release, a=0x0001+b=0x0001 → 0x0002.
- WIDTH=4 instance, all 16×16×2 combinations of a, b, cin → {cout,sum}=a+b+cin; latency 1 cycle each.
- With RCA_SEQ_OVF_EN: 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1; 0x8000+0x8000 → 0x0000, cout=1, ovf=1; 0xFFFF+0x0001 → ovf=0.
